// File: rtl/conv_psum_if.sv
// Pixel-in / feature-byte-out bundle of the conv partial-sum buffer.
// master drives pixels and out_ready; slave (the buffer) drives the feature stream.
interface conv_psum_if #(
    parameter int DIN_W = 24
);
    logic                    in_valid;
    logic [7:0]              in_addr;
    logic signed [DIN_W-1:0] in_data;
    logic                    chan_done;
    logic                    out_valid;
    logic                    out_ready;
    logic [7:0]              out_data;
    logic [7:0]              out_idx;
    logic                    out_last;

    modport master (
        output in_valid, in_addr, in_data, chan_done, out_ready,
        input  out_valid, out_data, out_idx, out_last
    );

    modport slave (
        input  in_valid, in_addr, in_data, chan_done, out_ready,
        output out_valid, out_data, out_idx, out_last
    );
endinterface

// File: rtl/conv_psum_buffer.sv
// Sums conv partials over CHAN passes into FV_LEN accumulators, then streams requantized bytes.
// Latency: write visible next cycle; first byte registered the cycle after the final chan_done.
// Backpressure: drain holds byte/idx/last while out_ready is low; PSUM_SAT_ACC_EN selects saturating accumulation.
module conv_psum_buffer #(
    parameter int ROWS  = 12,
    parameter int COLS  = 11,
    parameter int CHAN  = 10,
    parameter int DIN_W = 24,
    parameter int ACC_W = 28,
    parameter int SHIFT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    conv_psum_if.slave  bus,
    output logic        busy,
    output logic [3:0]  chan_cnt,
    output logic        err
);
    localparam int FV_LEN = ROWS * COLS;
`ifdef PSUM_SAT_ACC_EN
    localparam int SUM_W = ACC_W + 1;
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`else
    localparam int SUM_W = ACC_W;
`endif
    localparam logic signed [ACC_W-1:0] BYTE_MAX = ACC_W'(255);

    typedef enum logic [1:0] {S_ACCUM, S_DRAIN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q [FV_LEN];
    logic signed [ACC_W-1:0] acc_d [FV_LEN];
    logic [3:0]              cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    out_valid_q, out_valid_d;
    logic [7:0]              out_data_q, out_data_d;
    logic [7:0]              out_idx_q, out_idx_d;
    logic                    out_last_q, out_last_d;
    logic                    load;
    logic [7:0]              load_idx;
    logic signed [SUM_W-1:0] sum;

    function automatic logic [7:0] requant(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] s;
        s = a >>> SHIFT;
        if (s[ACC_W-1])
            return 8'd0;
        else if (s > BYTE_MAX)
            return 8'hFF;
        else
            return s[7:0];
    endfunction

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_last_d  = out_last_q;
        load        = 1'b0;
        load_idx    = '0;
        sum         = '0;

        if (clear) begin
            state_d     = S_ACCUM;
            for (int i = 0; i < FV_LEN; i++) acc_d[i] = '0;
            cnt_d       = '0;
            err_d       = 1'b0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_idx_d   = '0;
            out_last_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_ACCUM: begin
                    if (bus.in_valid) begin
                        if (bus.in_addr < 8'(FV_LEN)) begin
                            sum = SUM_W'(acc_q[bus.in_addr]) + SUM_W'(bus.in_data);
`ifdef PSUM_SAT_ACC_EN
                            if (sum[ACC_W] != sum[ACC_W-1]) begin
                                acc_d[bus.in_addr] = sum[ACC_W] ? ACC_MIN : ACC_MAX;
                                err_d              = 1'b1;
                            end else begin
                                acc_d[bus.in_addr] = sum[ACC_W-1:0];
                            end
`else
                            acc_d[bus.in_addr] = sum[ACC_W-1:0];
`endif
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    // Pixel in the same cycle as chan_done lands before the count moves.
                    if (bus.chan_done) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_d == 4'(CHAN)) begin
                            state_d     = S_DRAIN;
                            out_valid_d = 1'b1;
                            out_idx_d   = '0;
                            out_last_d  = (FV_LEN == 1);
                            load        = 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (bus.in_valid || bus.chan_done) err_d = 1'b1;
                    if (out_valid_q && bus.out_ready) begin
                        if (out_idx_q == 8'(FV_LEN - 1)) begin
                            state_d     = S_DONE;
                            out_valid_d = 1'b0;
                            out_data_d  = '0;
                            out_idx_d   = '0;
                            out_last_d  = 1'b0;
                        end else begin
                            out_idx_d  = out_idx_q + 8'd1;
                            out_last_d = (out_idx_d == 8'(FV_LEN - 1));
                            load       = 1'b1;
                            load_idx   = out_idx_d;
                        end
                    end
                end
                S_DONE: begin
                    if (bus.in_valid || bus.chan_done) err_d = 1'b1;
                end
                default: state_d = S_ACCUM;
            endcase
        end

        // Read from the next-state array so a final-pass pixel is included in byte 0.
        if (load) out_data_d = requant(acc_d[load_idx]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_ACCUM;
            for (int i = 0; i < FV_LEN; i++) acc_q[i] <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;
    assign busy          = (state_q == S_DRAIN);
    assign chan_cnt      = cnt_q;
    assign err           = err_q;
endmodule

// File: tb/tb_conv_psum_buffer.sv
// Scoreboard bench: two buffers (SHIFT=0 and SHIFT=2) share stimulus; a negedge monitor checks every accepted beat.
module tb_conv_psum_buffer;
    localparam int FV = 132;

    typedef struct {
        logic [7:0] data;
        logic [7:0] idx;
        logic       last;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       clear;
    logic       busy1, busy2, err1, err2;
    logic [3:0] cnt1, cnt2;

    int errors = 0;
    int checks = 0;
    int beats  = 0;

    beat_t      q1[$];
    logic [7:0] q2[$];
    logic [7:0] exp1 [FV];
    logic [7:0] exp2 [FV];

    logic       prev_stall = 1'b0;
    logic [7:0] prev_d, prev_i;
    logic       sat_mode;

    always #5 clk = ~clk;

    conv_psum_if #(.DIN_W(24)) b1();
    conv_psum_if #(.DIN_W(24)) b2();

    assign b2.in_valid  = b1.in_valid;
    assign b2.in_addr   = b1.in_addr;
    assign b2.in_data   = b1.in_data;
    assign b2.chan_done = b1.chan_done;
    assign b2.out_ready = b1.out_ready;

    conv_psum_buffer #(.DIN_W(24), .ACC_W(28), .SHIFT(0)) u_dut1 (
        .clk(clk), .rst(rst), .clear(clear), .bus(b1.slave),
        .busy(busy1), .chan_cnt(cnt1), .err(err1)
    );
    conv_psum_buffer #(.DIN_W(24), .ACC_W(28), .SHIFT(2)) u_dut2 (
        .clk(clk), .rst(rst), .clear(clear), .bus(b2.slave),
        .busy(busy2), .chan_cnt(cnt2), .err(err2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Control outputs of both instances must agree with the same expectation.
    task automatic chk_ctl(input string name, input logic busy_e, input logic [3:0] cnt_e, input logic err_e);
        chk({name, "_busy1"}, 32'(busy1), 32'(busy_e));
        chk({name, "_cnt1"},  32'(cnt1),  32'(cnt_e));
        chk({name, "_err1"},  32'(err1),  32'(err_e));
        chk({name, "_busy2"}, 32'(busy2), 32'(busy_e));
        chk({name, "_cnt2"},  32'(cnt2),  32'(cnt_e));
        chk({name, "_err2"},  32'(err2),  32'(err_e));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                checks++;
                if (!(b1.out_valid && b1.out_data == prev_d && b1.out_idx == prev_i)) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%0d d=%0d i=%0d expected v=1 d=%0d i=%0d",
                             b1.out_valid, b1.out_data, b1.out_idx, prev_d, prev_i);
                end
            end
            prev_stall = b1.out_valid && !b1.out_ready && !clear;
            prev_d     = b1.out_data;
            prev_i     = b1.out_idx;
            if (b1.out_valid && b1.out_ready && !clear) begin
                beat_t e;
                beats++;
                if (q1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL extra_beat: got idx %0d expected no beat", b1.out_idx);
                end else begin
                    e = q1.pop_front();
                    chk("beat_idx",  32'(b1.out_idx),  32'(e.idx));
                    chk("beat_data", 32'(b1.out_data), 32'(e.data));
                    chk("beat_last", 32'(b1.out_last), 32'(e.last));
                    chk("beat_vld2", 32'(b2.out_valid), 32'd1);
                    if (q2.size() > 0) chk("beat_data_sh2", 32'(b2.out_data), 32'(q2.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        b1.in_valid  = 1'b0;
        b1.in_addr   = '0;
        b1.in_data   = '0;
        b1.chan_done = 1'b0;
    endtask

    task automatic pix(input int a, input int d, input logic cd);
        b1.in_valid  = 1'b1;
        b1.in_addr   = 8'(a);
        b1.in_data   = 24'(d);
        b1.chan_done = cd;
        tick();
    endtask

    task automatic pass_end();
        b1.chan_done = 1'b1;
        tick();
        b1.chan_done = 1'b0;
    endtask

    task automatic zero_exp();
        for (int i = 0; i < FV; i++) begin
            exp1[i] = 8'd0;
            exp2[i] = 8'd0;
        end
    endtask

    task automatic push_exp(input int n);
        for (int i = 0; i < n; i++) begin
            beat_t e;
            e.data = exp1[i];
            e.idx  = 8'(i);
            e.last = (i == FV - 1);
            q1.push_back(e);
            q2.push_back(exp2[i]);
        end
    endtask

    task automatic wait_empty(input string name, input logic rand_ready);
        int c = 0;
        while ((q1.size() > 0 || busy1) && c < 3000) begin
            if (rand_ready) b1.out_ready = 1'($urandom_range(0, 1));
            tick();
            c++;
        end
        b1.out_ready = 1'b1;
        chk({name, "_drain_done"}, 32'(q1.size()), 32'd0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
`ifdef PSUM_SAT_ACC_EN
        sat_mode = 1'b1;
`else
        sat_mode = 1'b0;
`endif
        rst = 1'b1;
        clear = 1'b0;
        b1.out_ready = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_out_valid", 32'(b1.out_valid), 32'd0);
        chk("rst_out_data",  32'(b1.out_data),  32'd0);
        chk("rst_out_idx",   32'(b1.out_idx),   32'd0);
        chk("rst_out_last",  32'(b1.out_last),  32'd0);
        chk_ctl("rst", 1'b0, 4'd0, 1'b0);

        // Pass accumulation, negative/saturated bytes, back-to-back writes, same-cycle final pixel.
        zero_exp();
        exp1[1] = 8'd255; exp2[1] = 8'd250;
        exp1[2] = 8'd255; exp2[2] = 8'd250;
        exp1[5] = 8'd70;  exp2[5] = 8'd17;
        exp1[7] = 8'd9;   exp2[7] = 8'd2;
        exp1[9] = 8'd7;   exp2[9] = 8'd1;
        pix(5, 100, 0); pix(0, -200, 0); pix(1, 600, 0); pix(2, 1000, 0);
        pix(9, 3, 0); pix(9, 4, 0);
        idle();
        pass_end();
        pix(5, -30, 0); pix(0, -300, 0); pix(1, 400, 0);
        idle();
        pass_end();
        for (int p = 3; p <= 9; p++) pix(5, 0, 1);
        idle();
        chk_ctl("pass9", 1'b0, 4'd9, 1'b0);
        chk("pass9_out_valid", 32'(b1.out_valid), 32'd0);
        push_exp(FV);
        beats = 0;
        pix(7, 9, 1);
        idle();
        chk_ctl("drain_start", 1'b1, 4'd10, 1'b0);
        chk("drain_start_valid", 32'(b1.out_valid), 32'd1);
        chk("drain_start_idx",   32'(b1.out_idx),   32'd0);
        tick();
        pix(5, 1000, 0);
        idle();
        chk("drain_pix_err", 32'(err1), 32'd1);
        wait_empty("a", 1'b0);
        chk("a_beats", 32'(beats), 32'(FV));
        chk("a_done_valid", 32'(b1.out_valid), 32'd0);
        chk_ctl("a_done", 1'b0, 4'd10, 1'b1);

        // Overflow at addr 3, out-of-range address, random backpressure.
        do_clear();
        chk_ctl("clr_b", 1'b0, 4'd0, 1'b0);
        zero_exp();
        exp1[3] = sat_mode ? 8'd255 : 8'd0;
        exp2[3] = sat_mode ? 8'd255 : 8'd0;
        exp1[4] = 8'd50; exp2[4] = 8'd12;
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 16; k++) pix(3, 1 << 22, 0);
            idle();
            if (p == 0) pix(4, 50, 0);
            idle();
            pass_end();
        end
        chk("ovf_err", 32'(err1), 32'(sat_mode));
        pix(140, 77, 0);
        idle();
        chk_ctl("bad_addr", 1'b0, 4'd3, 1'b1);
        for (int p = 4; p <= 9; p++) pass_end();
        push_exp(FV);
        beats = 0;
        pass_end();
        wait_empty("b", 1'b1);
        chk("b_beats", 32'(beats), 32'(FV));

        // Clear aborts the stream after 50 beats.
        do_clear();
        zero_exp();
        exp1[10] = 8'd20; exp2[10] = 8'd5;
        pix(10, 20, 0);
        idle();
        for (int p = 1; p <= 9; p++) pass_end();
        push_exp(50);
        beats = 0;
        pass_end();
        begin
            int c = 0;
            while (beats < 50 && c < 200) begin
                tick();
                c++;
            end
        end
        chk("c_beats_before_clear", 32'(beats), 32'd50);
        do_clear();
        chk("c_clear_valid", 32'(b1.out_valid), 32'd0);
        chk("c_clear_idx",   32'(b1.out_idx),   32'd0);
        chk_ctl("c_clear", 1'b0, 4'd0, 1'b0);
        repeat (3) tick();
        chk("c_no_more_beats", 32'(beats), 32'd50);
        chk("c_queue_empty",   32'(q1.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
